// File: rtl/stopper_magazine.sv
// Stopper magazine controller: edge-detects dispense/refill commands, pulses the eject/load
// actuators and tracks inventory. Optional STOPPER_BCD_EN adds a registered BCD view of count.
module stopper_magazine #(
   parameter int CAPACITY    = 20,
   parameter int CNT_W       = 7,
   parameter int THRESH      = 5,
   parameter int ADD_AMOUNT  = 5,
   parameter int ACT_CYCLES  = 4,
   parameter int LOAD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             disp_in,
   input  logic             add_in,
   output logic             rolha5,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             eject,
   output logic             load,
   output logic             busy,
   output logic             fault,
   output logic             overrun
`ifdef STOPPER_BCD_EN
   ,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_units
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EJECT = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam int TMAX  = (ACT_CYCLES > LOAD_CYCLES) ? ACT_CYCLES : LOAD_CYCLES;
   localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic             d_prev;
   logic             a_prev;
   logic             pend_add;
   logic             pend_nx;
   logic             overrun_nx;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nx;
   logic [CNT_W-1:0] count_nx;
   logic             disp_rise;
   logic             add_rise;
   logic [CNT_W:0]   add_sum;
   logic [CNT_W-1:0] refill_cnt;

   assign disp_rise = disp_in & ~d_prev;
   assign add_rise  = add_in & ~a_prev;

   // One extra bit on the sum so the saturation compare sees the true total.
   assign add_sum    = {1'b0, count} + (CNT_W+1)'(ADD_AMOUNT);
   assign refill_cnt = (add_sum > (CNT_W+1)'(CAPACITY)) ? CNT_W'(CAPACITY)
                                                        : add_sum[CNT_W-1:0];

   always_comb begin
      state_nx   = state;
      count_nx   = count;
      timer_nx   = timer;
      pend_nx    = pend_add;
      overrun_nx = overrun;
      case (state)
         S_IDLE: begin
            if (disp_rise) begin
               if (add_rise)
                  pend_nx = 1'b1;
               if (count != '0) begin
                  state_nx = S_EJECT;
                  count_nx = count - CNT_W'(1);
                  timer_nx = TMR_W'(ACT_CYCLES - 1);
               end else begin
                  state_nx = S_FAULT;
               end
            end else if (add_rise || pend_add) begin
               state_nx = S_LOAD;
               count_nx = refill_cnt;
               timer_nx = TMR_W'(LOAD_CYCLES - 1);
               pend_nx  = 1'b0;
            end
         end
         S_EJECT, S_LOAD: begin
            if (disp_rise)
               overrun_nx = 1'b1;
            if (add_rise)
               pend_nx = 1'b1;
            if (timer == '0)
               state_nx = S_IDLE;
            else
               timer_nx = timer - TMR_W'(1);
         end
         S_FAULT: begin
            // Repeated dispense edges while empty are expected and not an overrun.
            if (add_rise) begin
               state_nx = S_LOAD;
               count_nx = refill_cnt;
               timer_nx = TMR_W'(LOAD_CYCLES - 1);
               pend_nx  = 1'b0;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         count    <= '0;
         timer    <= '0;
         d_prev   <= 1'b0;
         a_prev   <= 1'b0;
         pend_add <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         timer    <= timer_nx;
         d_prev   <= disp_in;
         a_prev   <= add_in;
         pend_add <= pend_nx;
         overrun  <= overrun_nx;
      end
   end

   assign eject  = (state == S_EJECT);
   assign load   = (state == S_LOAD);
   assign fault  = (state == S_FAULT);
   assign busy   = (state != S_IDLE);
   assign rolha5 = (count >= CNT_W'(THRESH));
   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(CAPACITY));

`ifdef STOPPER_BCD_EN
   logic [3:0] tens_nx;
   logic [3:0] units_nx;

   assign tens_nx  = 4'(count / CNT_W'(10));
   assign units_nx = 4'(count - CNT_W'(tens_nx) * CNT_W'(10));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd_tens  <= 4'd0;
         bcd_units <= 4'd0;
      end else begin
         bcd_tens  <= tens_nx;
         bcd_units <= units_nx;
      end
   end
`endif

endmodule
